// File: rtl/npu_ctrl_mc.sv
// NPU control register block: host-facing registers, sequencer job queue with
// dispatch FSM, per-channel DMA registers and sticky interrupt status.
module npu_ctrl_mc #(
    parameter int NUM_CH = 2,
    parameter int QDEPTH = 4,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    output logic                  irq,
    output logic                  seq_start,
    output logic [1:0]            seq_mode,
    output logic [31:0]           seq_total_rows,
    input  logic                  seq_busy,
    input  logic                  seq_done,
    output logic [32*NUM_CH-1:0]  dma_rd_addr,
    output logic [32*NUM_CH-1:0]  dma_rd_len,
    output logic [32*NUM_CH-1:0]  dma_wr_addr,
    output logic [32*NUM_CH-1:0]  dma_wr_len,
    output logic [NUM_CH-1:0]     dma_rd_start,
    output logic [NUM_CH-1:0]     dma_wr_start,
    input  logic [NUM_CH-1:0]     dma_rd_busy,
    input  logic [NUM_CH-1:0]     dma_wr_busy,
    input  logic [NUM_CH-1:0]     dma_rd_done,
    input  logic [NUM_CH-1:0]     dma_wr_done
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_W-1:0] A_JOB   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_ROWS  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ISTAT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_IEN   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_FLUSH = ADDR_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] rows;
    } job_t;

    state_t                   state_q, state_d;
    job_t [QDEPTH-1:0]        mem_q, mem_d;
    logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [31:0]              rows_q, rows_d;
    logic [15:0]              irq_stat_q, irq_stat_d;
    logic [15:0]              irq_en_q, irq_en_d;
    logic                     irq_q, irq_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;
    logic [1:0]               seq_mode_q, seq_mode_d;
    logic [31:0]              seq_rows_q, seq_rows_d;
    logic [NUM_CH-1:0][31:0]  rd_addr_q, rd_addr_d, rd_len_q, rd_len_d;
    logic [NUM_CH-1:0][31:0]  wr_addr_q, wr_addr_d, wr_len_q, wr_len_d;
    logic [NUM_CH-1:0]        rd_start_q, rd_start_d, wr_start_q, wr_start_d;

    logic [NUM_CH-1:0]        ch_hit;
    logic                     full, empty, flush, push_req, push_ok, pop;
    logic [15:0]              stat_set, stat_clr;
    logic [31:0]              status, rmux;

    // Channel c occupies words 8+8c .. 8+8c+7; absent channels never match.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            ch_hit[c] = (address[ADDR_W-1:3] == (ADDR_W-3)'(c + 1));
    end

    assign full     = (count_q == CW'(QDEPTH));
    assign empty    = (count_q == '0);
    assign flush    = write && (address == A_FLUSH) && writedata[0];
    assign push_req = write && (address == A_JOB) && writedata[0];
    assign pop      = (state_q == S_IDLE) && !empty && !seq_busy && !flush;
    // A pop in the same cycle frees the slot, and a flush empties the queue first.
    assign push_ok  = push_req && (flush || !full || pop);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = flush ? wptr_q : rptr_q + PW'(pop);
        count_d = flush ? CW'(push_ok) : count_q + CW'(push_ok) - CW'(pop);
        if (push_ok)
            mem_d[wptr_q] = '{mode: writedata[2:1], rows: rows_q};
    end

    always_comb begin
        state_d    = state_q;
        seq_mode_d = seq_mode_q;
        seq_rows_d = seq_rows_q;
        case (state_q)
            S_IDLE: if (pop) begin
                seq_mode_d = mem_q[rptr_q].mode;
                seq_rows_d = mem_q[rptr_q].rows;
                state_d    = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (seq_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stat_set     = '0;
        stat_set[0]  = seq_done;
        stat_set[15] = push_req && !push_ok;
        for (int c = 0; c < NUM_CH; c++) begin
            stat_set[1+2*c] = dma_rd_done[c];
            stat_set[2+2*c] = dma_wr_done[c];
        end
        stat_clr   = (write && address == A_ISTAT) ? writedata[15:0] : 16'd0;
        irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
        irq_en_d   = (write && address == A_IEN) ? writedata[15:0] : irq_en_q;
        rows_d     = (write && address == A_ROWS) ? writedata : rows_q;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        wr_addr_d = wr_addr_q;
        wr_len_d  = wr_len_q;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_start_d[c] = 1'b0;
            wr_start_d[c] = 1'b0;
            if (write && ch_hit[c]) begin
                case (address[2:0])
                    3'd0: rd_addr_d[c] = writedata;
                    3'd1: rd_len_d[c]  = writedata;
                    3'd2: wr_addr_d[c] = writedata;
                    3'd3: wr_len_d[c]  = writedata;
                    3'd4: begin
                        rd_start_d[c] = writedata[0] && !dma_rd_busy[c];
                        wr_start_d[c] = writedata[1] && !dma_wr_busy[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        status    = '0;
        status[0] = seq_busy;
        status[1] = (state_q != S_IDLE);
        for (int c = 0; c < NUM_CH; c++) begin
            status[8+2*c] = dma_rd_busy[c];
            status[9+2*c] = dma_wr_busy[c];
        end
    end

    always_comb begin
        rmux = '0;
        case (address)
            A_JOB:   rmux = {16'd0, 8'(count_q), 5'd0, full, empty, 1'b0};
            A_ROWS:  rmux = rows_q;
            A_ISTAT: rmux = {16'd0, irq_stat_q};
            A_IEN:   rmux = {16'd0, irq_en_q};
            A_STAT:  rmux = status;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_hit[c]) begin
                        case (address[2:0])
                            3'd0: rmux = rd_addr_q[c];
                            3'd1: rmux = rd_len_q[c];
                            3'd2: rmux = wr_addr_q[c];
                            3'd3: rmux = wr_len_q[c];
                            3'd4: rmux = {28'd0, irq_stat_q[2+2*c], irq_stat_q[1+2*c],
                                          dma_wr_busy[c], dma_rd_busy[c]};
                            default: ;
                        endcase
                    end
                end
            end
        endcase
        rdata_d  = read ? rmux : 32'd0;
        rvalid_d = read;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rows_q     <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            seq_mode_q <= '0;
            seq_rows_q <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            rd_start_q <= '0;
            wr_start_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rows_q     <= rows_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            seq_mode_q <= seq_mode_d;
            seq_rows_q <= seq_rows_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
        end
    end

    assign readdata       = rdata_q;
    assign readdatavalid  = rvalid_q;
    assign irq            = irq_q;
    assign seq_start      = (state_q == S_ISSUE);
    assign seq_mode       = seq_mode_q;
    assign seq_total_rows = seq_rows_q;
    assign dma_rd_addr    = rd_addr_q;
    assign dma_rd_len     = rd_len_q;
    assign dma_wr_addr    = wr_addr_q;
    assign dma_wr_len     = wr_len_q;
    assign dma_rd_start   = rd_start_q;
    assign dma_wr_start   = wr_start_q;

endmodule

// File: tb/tb_npu_ctrl_mc.sv
// Self-checking bench for npu_ctrl_mc: register table, job dispatch scoreboard,
// queue overflow/flush, DMA start pulses, sticky W1C race and mid-run reset.
module tb_npu_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  address = '0;
    logic        write = 1'b0, read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid, irq, seq_start;
    logic [1:0]  seq_mode;
    logic [31:0] seq_total_rows;
    logic        seq_busy = 1'b0, seq_done = 1'b0;
    logic [63:0] dma_rd_addr, dma_rd_len, dma_wr_addr, dma_wr_len;
    logic [1:0]  dma_rd_start, dma_wr_start;
    logic [1:0]  dma_rd_busy = '0, dma_wr_busy = '0, dma_rd_done = '0, dma_wr_done = '0;

    npu_ctrl_mc #(.NUM_CH(2), .QDEPTH(4), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq),
        .seq_start(seq_start), .seq_mode(seq_mode), .seq_total_rows(seq_total_rows),
        .seq_busy(seq_busy), .seq_done(seq_done),
        .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
        .dma_wr_addr(dma_wr_addr), .dma_wr_len(dma_wr_len),
        .dma_rd_start(dma_rd_start), .dma_wr_start(dma_wr_start),
        .dma_rd_busy(dma_rd_busy), .dma_wr_busy(dma_wr_busy),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [31:0] rd_q [$];
    logic [33:0] job_q [$];

    typedef struct {
        logic [5:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboards: read responses and launched jobs are matched in order.
    always @(negedge clk) begin
        if (readdatavalid) begin
            if (rd_q.size() == 0) chk("rdv_unexpected", 64'd1, 64'd0);
            else chk("readdata", {32'd0, readdata}, {32'd0, rd_q.pop_front()});
        end
        if (seq_start) begin
            start_cnt++;
            if (job_q.size() == 0) chk("seq_start_unexpected", 64'd1, 64'd0);
            else chk("seq_job", {30'd0, seq_mode, seq_total_rows}, {30'd0, job_q.pop_front()});
        end
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp);
        address = a; read = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wait_start(input int prev, input string nm);
        int n = 0;
        while (start_cnt <= prev && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (start_cnt <= prev) begin
            errors++;
            $display("FAIL %s: no seq_start within 20 cycles, got %0d starts expected >%0d", nm, start_cnt, prev);
        end
    endtask

    task automatic finish_job();
        seq_busy = 1'b1;
        repeat (2) @(negedge clk);
        seq_done = 1'b1; seq_busy = 1'b0;
        @(negedge clk);
        seq_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        logic [5:0] ra [16] = '{0,1,2,3,4,5,8,9,10,11,12,16,17,18,19,20};

        tbl[0]  = '{6'd1,  1'b1, 32'd64,        32'd64};
        tbl[1]  = '{6'd3,  1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF};
        tbl[2]  = '{6'd3,  1'b1, 32'd0,         32'd0};
        tbl[3]  = '{6'd8,  1'b1, 32'hA0,        32'hA0};
        tbl[4]  = '{6'd9,  1'b1, 32'h11,        32'h11};
        tbl[5]  = '{6'd10, 1'b1, 32'hB0,        32'hB0};
        tbl[6]  = '{6'd11, 1'b1, 32'h22,        32'h22};
        tbl[7]  = '{6'd18, 1'b1, 32'h2000,      32'h2000};
        tbl[8]  = '{6'd19, 1'b1, 32'h33,        32'h33};
        tbl[9]  = '{6'd24, 1'b1, 32'hDEAD,      32'd0};
        tbl[10] = '{6'd6,  1'b1, 32'd5,         32'd0};
        tbl[11] = '{6'd4,  1'b1, 32'hFFFF,      32'd0};
        tbl[12] = '{6'd13, 1'b1, 32'd7,         32'd0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_seq", {29'd0, seq_start, seq_mode, seq_total_rows}, 64'd0);
        chk("rst_dma_rd_addr", dma_rd_addr, 64'd0);
        chk("rst_dma_starts", {60'd0, dma_rd_start, dma_wr_start}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        foreach (ra[i]) rd(ra[i], (ra[i] == 6'd0) ? 32'h2 : 32'h0);

        // Register table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            rd(tbl[i].a, tbl[i].exp);
        end
        chk("dma_wr_addr1", {32'd0, dma_wr_addr[63:32]}, 64'h2000);
        // Read and write same address in one cycle returns the old value
        address = 6'd1; writedata = 32'd99; write = 1'b1; read = 1'b1;
        rd_q.push_back(32'd64);
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        rd(6'd1, 32'd99);

        // Two jobs: second launches only after seq_done
        wr(6'd1, 32'd64);
        job_q.push_back({2'd1, 32'd64});
        p = start_cnt;
        wr(6'd0, 32'h3);
        wait_start(p, "job1_start");
        seq_busy = 1'b1;
        wr(6'd1, 32'd128);
        job_q.push_back({2'd2, 32'd128});
        p = start_cnt;
        wr(6'd0, 32'h5);
        rd(6'd0, 32'h100);
        rd(6'd4, 32'h3);
        repeat (3) @(negedge clk);
        chk("no_early_start", 64'(start_cnt), 64'(p));
        seq_done = 1'b1; seq_busy = 1'b0;
        @(negedge clk);
        seq_done = 1'b0;
        wait_start(p, "job2_start");
        finish_job();
        rd(6'd2, 32'h1);
        wr(6'd2, 32'h1);
        rd(6'd2, 32'h0);

        // Fill the queue, then push while full in the same cycle as a pop
        seq_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(6'd1, 32'(100 + i));
            job_q.push_back({2'(i), 32'(100 + i)});
            wr(6'd0, {29'd0, 2'(i), 1'b1});
        end
        rd(6'd0, 32'h404);
        wr(6'd1, 32'd200);
        job_q.push_back({2'd3, 32'd200});
        p = start_cnt;
        seq_busy = 1'b0;
        wr(6'd0, 32'h7);
        rd(6'd0, 32'h404);
        rd(6'd2, 32'h0);
        for (int k = 0; k < 5; k++) begin
            wait_start(p, "drain_start");
            p = start_cnt;
            finish_job();
        end
        rd(6'd0, 32'h2);
        wr(6'd2, 32'h1);

        // Overflow, irq, W1C and flush
        seq_busy = 1'b1;
        for (int i = 0; i < 5; i++) wr(6'd0, 32'h1);
        rd(6'd0, 32'h404);
        rd(6'd2, 32'h8000);
        chk("irq_before_en", {63'd0, irq}, 64'd0);
        wr(6'd3, 32'h8000);
        chk("irq_lag", {63'd0, irq}, 64'd0);
        @(negedge clk);
        chk("irq_rise", {63'd0, irq}, 64'd1);
        wr(6'd2, 32'h8000);
        @(negedge clk);
        chk("irq_clear", {63'd0, irq}, 64'd0);
        rd(6'd2, 32'h0);
        wr(6'd5, 32'h1);
        rd(6'd0, 32'h2);
        p = start_cnt;
        seq_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_no_start", 64'(start_cnt), 64'(p));
        wr(6'd3, 32'h0);

        // DMA channel 1 read start and busy suppression
        wr(6'd16, 32'h1000);
        wr(6'd17, 32'd256);
        chk("ch1_rd_addr", {32'd0, dma_rd_addr[63:32]}, 64'h1000);
        chk("ch1_rd_len", {32'd0, dma_rd_len[63:32]}, 64'd256);
        wr(6'd20, 32'h1);
        chk("rd_start_pulse", {62'd0, dma_rd_start}, 64'h2);
        @(negedge clk);
        chk("rd_start_once", {62'd0, dma_rd_start}, 64'h0);
        dma_rd_busy = 2'b10;
        wr(6'd20, 32'h1);
        chk("rd_start_busy", {62'd0, dma_rd_start}, 64'h0);
        @(negedge clk);
        chk("rd_start_busy2", {62'd0, dma_rd_start}, 64'h0);
        rd(6'd20, 32'h1);
        rd(6'd4, 32'h400);
        dma_rd_busy = 2'b00;
        wr(6'd12, 32'h2);
        chk("wr_start_ch0", {60'd0, dma_wr_start, dma_rd_start}, 64'h4);

        // Sticky set wins over a same-cycle W1C
        dma_wr_done = 2'b01;
        @(negedge clk);
        dma_wr_done = 2'b00;
        rd(6'd2, 32'h4);
        dma_wr_done = 2'b01;
        wr(6'd2, 32'h4);
        dma_wr_done = 2'b00;
        rd(6'd2, 32'h4);
        rd(6'd12, 32'h8);
        wr(6'd2, 32'h4);
        rd(6'd2, 32'h0);
        dma_rd_done = 2'b10;
        @(negedge clk);
        dma_rd_done = 2'b00;
        rd(6'd2, 32'h8);
        rd(6'd20, 32'h4);
        wr(6'd2, 32'hFFFF);

        // Reset while waiting with two jobs queued
        wr(6'd1, 32'd50);
        job_q.push_back({2'd1, 32'd50});
        p = start_cnt;
        for (int i = 0; i < 3; i++) wr(6'd0, 32'h3);
        wait_start(p, "rst_job_start");
        seq_busy = 1'b1;
        rd(6'd0, 32'h200);
        rd(6'd4, 32'h3);
        rst = 1'b1;
        seq_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_seq", {29'd0, seq_start, seq_mode, seq_total_rows}, 64'd0);
        chk("midrst_dma", dma_rd_addr | dma_wr_len, 64'd0);
        rst = 1'b0;
        p = start_cnt;
        repeat (8) @(negedge clk);
        chk("midrst_no_start", 64'(start_cnt), 64'(p));
        rd(6'd0, 32'h2);
        rd(6'd4, 32'h0);
        rd(6'd1, 32'h0);
        chk("midrst_irq", {63'd0, irq}, 64'd0);

        repeat (2) @(negedge clk);
        chk("rd_pending", 64'(rd_q.size()), 64'd0);
        chk("job_pending", 64'(job_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
